// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between an instruction-fetch port and a
// load/store data port: one access per four cycles, data first, bounded fetch wait.
module mem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_done,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_DONE} state_t;

  localparam int                STREAK_W   = $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  state_t              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                owner_q, owner_d;   // 1 = data port owns the access
  logic                we_q, we_d;
  logic                ram_read_q, ram_read_d;
  logic                ram_write_q, ram_write_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                f_done_q, f_done_d;
  logic                d_done_q, d_done_d;
  logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                busy_q, busy_d;

  logic data_grant;
  assign data_grant = d_req && !(f_req && (streak_q == STREAK_MAX));

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    owner_d     = owner_q;
    we_d        = we_q;
    ram_read_d  = 1'b0;
    ram_write_d = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    f_done_d    = 1'b0;
    d_done_d    = 1'b0;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        // RAM pins are loaded at grant so they are valid for exactly the ACCESS cycle
        if (data_grant) begin
          state_d     = S_ACCESS;
          owner_d     = 1'b1;
          we_d        = d_we;
          ram_addr_d  = d_addr;
          ram_write_d = d_we;
          ram_read_d  = !d_we;
          ram_wdata_d = d_wdata;
          if (!f_req)
            streak_d = '0;
          else if (streak_q != STREAK_MAX)
            streak_d = streak_q + 1'b1;
        end else if (f_req) begin
          state_d    = S_ACCESS;
          owner_d    = 1'b0;
          we_d       = 1'b0;
          ram_addr_d = f_addr;
          ram_read_d = 1'b1;
          streak_d   = '0;
        end
      end
      S_ACCESS: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_DONE;
        if (!we_q) begin
          if (owner_q) d_rdata_d = ram_rdata;
          else         f_rdata_d = ram_rdata;
        end
        d_done_d = owner_q;
        f_done_d = !owner_q;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= S_IDLE;
      streak_q    <= '0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      f_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      f_done_q    <= f_done_d;
      d_done_q    <= d_done_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign ram_read  = ram_read_q;
  assign ram_write = ram_write_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign f_done    = f_done_q;
  assign d_done    = d_done_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural 512x32 RAM, table of directed accesses,
// reset/collision/starvation sequences and a random mix, checked by a done scoreboard.
module tb_mem_port_arbiter;

  logic        clock;
  logic        clear;
  logic        f_req;
  logic [8:0]  f_addr;
  logic        f_done;
  logic [31:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [8:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        ram_read;
  logic        ram_write;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        busy;

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_STREAK(4)) dut (
    .clock(clock), .clear(clear),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural RAM: write and 1-cycle registered read at the end of the access cycle
  logic [31:0] ram_mem [0:511];
  always @(posedge clock) begin
    if (ram_write) ram_mem[ram_addr] <= ram_wdata;
    if (ram_read)  ram_rdata <= ram_mem[ram_addr];
  end

  typedef struct {
    bit          is_data;
    bit          is_read;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    bit          is_data;
    bit          we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  sb_t         sb_q[$];
  logic [31:0] sh_mem [0:511];
  logic [31:0] exp_f_rdata, exp_d_rdata;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no done within cycle budget", name);
  endtask

  // Scoreboard: every done pulse pops one expected transaction
  always @(negedge clock) begin
    if (clear) begin
      exp_f_rdata = '0;
      exp_d_rdata = '0;
    end else begin
      chk("rw_exclusive", 32'(ram_read & ram_write), 32'd0);
      if (f_done || d_done) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_done: actual f_done=%0d d_done=%0d required none", f_done, d_done);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("done_both", 32'(f_done & d_done), 32'd0);
          chk("done_port", 32'(d_done), 32'(e.is_data));
          if (e.is_read) begin
            if (e.is_data) exp_d_rdata = e.data;
            else           exp_f_rdata = e.data;
          end
          chk("f_rdata", f_rdata, exp_f_rdata);
          chk("d_rdata", d_rdata, exp_d_rdata);
          $display("txn %s %s f_rdata=%h d_rdata=%h", e.is_data ? "data " : "fetch",
                   e.is_read ? "read " : "write", f_rdata, d_rdata);
        end
      end
    end
  end

  task automatic push_exp(input bit is_data, input bit is_read, input logic [31:0] data);
    sb_t e;
    e.is_data = is_data;
    e.is_read = is_read;
    e.data    = data;
    sb_q.push_back(e);
  endtask

  // One single-port transaction, driven at a negedge and checked cycle by cycle
  task automatic do_txn(input bit is_data, input bit we, input logic [8:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd);
    bit got;
    push_exp(is_data, !we, exp_rd);
    @(negedge clock);
    if (is_data) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    got = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clock);
      if (k == 1) begin
        chk("access_read", 32'(ram_read), 32'(!we));
        chk("access_write", 32'(ram_write), 32'(we));
        chk("access_addr", 32'(ram_addr), 32'(addr));
        chk("access_busy", 32'(busy), 32'd1);
        if (we) chk("access_wdata", ram_wdata, wdata);
      end
      if (k == 2) chk("capture_pins_low", 32'(ram_read | ram_write), 32'd0);
      if ((is_data && d_done) || (!is_data && f_done)) begin
        got = 1'b1;
        chk("latency", 32'(k), 32'd3);
        chk("ram_pins_in_done", 32'(ram_read | ram_write), 32'd0);
      end
    end
    if (!got) fail_now("txn_done");
    f_req = 1'b0;
    d_req = 1'b0;
  endtask

  vec_t vecs [10];

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram_mem[i] = 32'hC0DE_0000 | i;
      sh_mem[i]  = 32'hC0DE_0000 | i;
    end
    ram_mem[0] = 32'h1234_5678;
    sh_mem[0]  = 32'h1234_5678;

    vecs[0] = '{1'b0, 1'b0, 9'h000, 32'h0,         32'h1234_5678};
    vecs[1] = '{1'b1, 1'b1, 9'h057, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 9'h057, 32'h0,         32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b0, 9'h057, 32'h0,         32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 1'b0, 9'h100, 32'h0,         32'hC0DE_0100};
    vecs[5] = '{1'b1, 1'b1, 9'h1FF, 32'hA5A5_5A5A, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 9'h1FF, 32'h0,         32'hA5A5_5A5A};
    vecs[7] = '{1'b1, 1'b1, 9'h000, 32'h0BAD_F00D, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 9'h000, 32'h0,         32'h0BAD_F00D};
    vecs[9] = '{1'b0, 1'b0, 9'h001, 32'h0,         32'hC0DE_0001};

    clear = 1'b1; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'({f_done, d_done}), 32'd0);
    chk("rst_ram_pins", 32'({ram_read, ram_write}), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_f_rdata", f_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    clear = 1'b0;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].we) sh_mem[vecs[i].addr] = vecs[i].wdata;
      do_txn(vecs[i].is_data, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
    end

    // Reset in the middle of an ACCESS cycle aborts the load with no done
    @(negedge clock);
    d_req = 1'b1; d_we = 1'b0; d_addr = 9'h010;
    @(negedge clock);
    chk("abort_access_read", 32'(ram_read), 32'd1);
    clear = 1'b1; d_req = 1'b0;
    @(negedge clock);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ram_pins", 32'({ram_read, ram_write}), 32'd0);
    chk("abort_ram_addr", 32'(ram_addr), 32'd0);
    chk("abort_rdata", f_rdata | d_rdata, 32'd0);
    clear = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("abort_no_done", 32'({f_done, d_done}), 32'd0);
    end

    // Collision: data first, fetch granted four cycles later
    begin
      int d_at, f_at;
      d_at = 0; f_at = 0;
      push_exp(1'b1, 1'b1, sh_mem[9'h057]);
      push_exp(1'b0, 1'b1, sh_mem[9'h001]);
      @(negedge clock);
      d_req = 1'b1; d_we = 1'b0; d_addr = 9'h057;
      f_req = 1'b1; f_addr = 9'h001;
      for (int k = 1; k <= 20 && f_at == 0; k++) begin
        @(negedge clock);
        if (k == 1) chk("coll_first_addr", 32'(ram_addr), 32'h057);
        if (k == 5) begin
          chk("coll_fetch_read", 32'(ram_read), 32'd1);
          chk("coll_fetch_addr", 32'(ram_addr), 32'h001);
        end
        if (d_done) begin d_at = k; d_req = 1'b0; end
        if (f_done) begin f_at = k; f_req = 1'b0; end
      end
      chk("coll_d_done_cycle", 32'(d_at), 32'd3);
      chk("coll_f_done_cycle", 32'(f_at), 32'd7);
      f_req = 1'b0; d_req = 1'b0;
    end

    // Starvation: four data grants, one fetch, then data resumes
    begin
      logic [6:0] seq;
      int         n;
      seq = 7'b1101111;
      n = 0;
      for (int i = 0; i < 7; i++) begin
        if (seq[i]) push_exp(1'b1, 1'b1, sh_mem[9'h057]);
        else        push_exp(1'b0, 1'b1, sh_mem[9'h000]);
      end
      @(negedge clock);
      d_req = 1'b1; d_we = 1'b0; d_addr = 9'h057;
      f_req = 1'b1; f_addr = 9'h000;
      for (int k = 1; k <= 60 && n < 7; k++) begin
        @(negedge clock);
        if (f_done || d_done) begin
          chk("starve_order", 32'(d_done), 32'(seq[n]));
          if (f_done) f_req = 1'b0;
          n++;
        end
      end
      if (n < 7) fail_now("starve_sequence");
      d_req = 1'b0; f_req = 1'b0;
    end

    // Random mix of single-port accesses
    for (int i = 0; i < 200; i++) begin
      bit          is_data, we;
      logic [8:0]  addr;
      logic [31:0] wdata, exp_rd;
      is_data = 1'($urandom_range(0, 1));
      we      = is_data ? 1'($urandom_range(0, 1)) : 1'b0;
      addr    = 9'($urandom_range(0, 31));
      wdata   = $urandom;
      exp_rd  = we ? 32'h0 : sh_mem[addr];
      if (we) sh_mem[addr] = wdata;
      repeat ($urandom_range(0, 2)) @(negedge clock);
      do_txn(is_data, we, addr, wdata, exp_rd);
    end

    repeat (4) @(negedge clock);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
